// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer write scheduler.
package fb_pkg;

  localparam int unsigned DefWRes = 640;
  localparam int unsigned DefHRes = 480;
  localparam int unsigned DefCw   = 11;

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StFill
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

endpackage

// File: rtl/fb_rect_clip.sv
// Combinational clip of a rectangle command to the screen, with degenerate-command detect.
module fb_rect_clip
  import fb_pkg::*;
#(
  parameter int unsigned W_RES = DefWRes,
  parameter int unsigned H_RES = DefHRes,
  parameter int unsigned CW    = DefCw
) (
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  logic [CW-1:0] w_i,
  input  logic [CW-1:0] h_i,
  output logic [CW-1:0] x0_o,
  output logic [CW-1:0] y0_o,
  output logic [CW-1:0] x1_o,
  output logic [CW-1:0] y1_o,
  output logic          empty_o
);

  localparam int unsigned CwP1 = CW + 1;
  localparam logic [CW:0] XLastW = CwP1'(W_RES - 1);
  localparam logic [CW:0] YLastW = CwP1'(H_RES - 1);
  localparam logic [CW:0] XResW  = CwP1'(W_RES);
  localparam logic [CW:0] YResW  = CwP1'(H_RES);

  logic [CW:0] x_end;
  logic [CW:0] y_end;

  always_comb begin
    // One extra bit so x+w-1 cannot wrap before the clamp.
    x_end   = {1'b0, x_i} + {1'b0, w_i} - CwP1'(1);
    y_end   = {1'b0, y_i} + {1'b0, h_i} - CwP1'(1);
    x0_o    = x_i;
    y0_o    = y_i;
    x1_o    = (x_end > XLastW) ? XLastW[CW-1:0] : x_end[CW-1:0];
    y1_o    = (y_end > YLastW) ? YLastW[CW-1:0] : y_end[CW-1:0];
    empty_o = (w_i == '0) || (h_i == '0) || ({1'b0, x_i} >= XResW) || ({1'b0, y_i} >= YResW);
  end

endmodule

// File: rtl/fb_write_sched.sv
// Framebuffer write-port owner: full-screen clear and clipped rectangle fills, one pixel per clock.
// Optional CLEAR_PREEMPT_EN lets a clear request abort a fill in progress.
module fb_write_sched
  import fb_pkg::*;
#(
  parameter int unsigned W_RES = DefWRes,
  parameter int unsigned H_RES = DefHRes,
  parameter int unsigned CW    = DefCw
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear_req,
  input  logic [23:0]   clear_rgb,
  input  logic          rect_valid,
  output logic          rect_ready,
  input  logic [CW-1:0] rect_x,
  input  logic [CW-1:0] rect_y,
  input  logic [CW-1:0] rect_w,
  input  logic [CW-1:0] rect_h,
  input  logic [23:0]   rect_rgb,
  output logic          wr_en,
  output logic [CW-1:0] wr_x,
  output logic [CW-1:0] wr_y,
  output logic [23:0]   wr_rgb,
  output logic          busy,
  output logic          rect_done,
  output logic          clear_done,
  output logic          rect_abort
);

  localparam logic [CW-1:0] XLast = CW'(W_RES - 1);
  localparam logic [CW-1:0] YLast = CW'(H_RES - 1);

  state_e        state_q, state_d;
  logic          pending_q, pending_d;
  logic [CW-1:0] cur_x_q, cur_x_d;
  logic [CW-1:0] cur_y_q, cur_y_d;
  logic [CW-1:0] x0_q, x0_d;
  logic [CW-1:0] x1_q, x1_d;
  logic [CW-1:0] y1_q, y1_d;
  rgb_t          rgb_q, rgb_d;
  logic          wr_en_q, wr_en_d;
  logic          busy_q, busy_d;
  logic          rect_done_q, rect_done_d;
  logic          clear_done_q, clear_done_d;
  logic          abort_d;
  logic          start_clear;

  logic [CW-1:0] clip_x0, clip_y0, clip_x1, clip_y1;
  logic          clip_empty;

  fb_rect_clip #(
    .W_RES (W_RES),
    .H_RES (H_RES),
    .CW    (CW)
  ) u_clip (
    .x_i     (rect_x),
    .y_i     (rect_y),
    .w_i     (rect_w),
    .h_i     (rect_h),
    .x0_o    (clip_x0),
    .y0_o    (clip_y0),
    .x1_o    (clip_x1),
    .y1_o    (clip_y1),
    .empty_o (clip_empty)
  );

  logic          at_row_end, at_last, nxt_last;
  logic [CW-1:0] nxt_x, nxt_y;

  always_comb begin
    at_row_end = (cur_x_q == x1_q);
    at_last    = at_row_end && (cur_y_q == y1_q);
    nxt_x      = at_row_end ? x0_q : cur_x_q + 1'b1;
    nxt_y      = at_row_end ? cur_y_q + 1'b1 : cur_y_q;
    nxt_last   = (nxt_x == x1_q) && (nxt_y == y1_q);
  end

  // Clear has priority: a same-cycle clear_req holds off the command.
  assign rect_ready = (state_q == StIdle) && !pending_q && !clear_req && !reset;

  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q | (clear_req && (state_q != StClear));
    cur_x_d      = cur_x_q;
    cur_y_d      = cur_y_q;
    x0_d         = x0_q;
    x1_d         = x1_q;
    y1_d         = y1_q;
    rgb_d        = rgb_q;
    wr_en_d      = 1'b0;
    rect_done_d  = 1'b0;
    clear_done_d = 1'b0;
    abort_d      = 1'b0;
    start_clear  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          start_clear = 1'b1;
        end else if (rect_valid && rect_ready) begin
          if (clip_empty) begin
            rect_done_d = 1'b1;
          end else begin
            state_d     = StFill;
            cur_x_d     = clip_x0;
            cur_y_d     = clip_y0;
            x0_d        = clip_x0;
            x1_d        = clip_x1;
            y1_d        = clip_y1;
            rgb_d       = rgb_t'(rect_rgb);
            wr_en_d     = 1'b1;
            rect_done_d = (clip_x0 == clip_x1) && (clip_y0 == clip_y1);
          end
        end
      end
      StFill, StClear: begin
        if (at_last) begin
          state_d = StIdle;
`ifdef CLEAR_PREEMPT_EN
        end else if ((state_q == StFill) && clear_req) begin
          start_clear = 1'b1;
          abort_d     = 1'b1;
`endif
        end else begin
          cur_x_d      = nxt_x;
          cur_y_d      = nxt_y;
          wr_en_d      = 1'b1;
          rect_done_d  = (state_q == StFill) && nxt_last;
          clear_done_d = (state_q == StClear) && nxt_last;
        end
      end
      default: state_d = StIdle;
    endcase

    if (start_clear) begin
      state_d      = StClear;
      pending_d    = 1'b0;
      cur_x_d      = '0;
      cur_y_d      = '0;
      x0_d         = '0;
      x1_d         = XLast;
      y1_d         = YLast;
      rgb_d        = rgb_t'(clear_rgb);
      wr_en_d      = 1'b1;
      clear_done_d = (XLast == '0) && (YLast == '0);
    end

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      pending_q    <= 1'b0;
      cur_x_q      <= '0;
      cur_y_q      <= '0;
      x0_q         <= '0;
      x1_q         <= '0;
      y1_q         <= '0;
      rgb_q        <= '0;
      wr_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      rect_done_q  <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      cur_x_q      <= cur_x_d;
      cur_y_q      <= cur_y_d;
      x0_q         <= x0_d;
      x1_q         <= x1_d;
      y1_q         <= y1_d;
      rgb_q        <= rgb_d;
      wr_en_q      <= wr_en_d;
      busy_q       <= busy_d;
      rect_done_q  <= rect_done_d;
      clear_done_q <= clear_done_d;
    end
  end

`ifdef CLEAR_PREEMPT_EN
  logic abort_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_d;
    end
  end

  assign rect_abort = abort_q;
`else
  assign rect_abort = 1'b0;
`endif

  assign wr_en      = wr_en_q;
  assign wr_x       = cur_x_q;
  assign wr_y       = cur_y_q;
  assign wr_rgb     = rgb_q;
  assign busy       = busy_q;
  assign rect_done  = rect_done_q;
  assign clear_done = clear_done_q;

endmodule

// File: tb/tb_fb_write_sched.sv
// Self-checking bench for fb_write_sched on a reduced 128x96 screen to keep full clears short.
module tb_fb_write_sched;

  localparam int unsigned W  = 128;
  localparam int unsigned H  = 96;
  localparam int unsigned CW = 11;

  logic          clock = 1'b0;
  logic          reset;
  logic          clear_req;
  logic [23:0]   clear_rgb;
  logic          rect_valid;
  logic          rect_ready;
  logic [CW-1:0] rect_x, rect_y, rect_w, rect_h;
  logic [23:0]   rect_rgb;
  logic          wr_en;
  logic [CW-1:0] wr_x, wr_y;
  logic [23:0]   wr_rgb;
  logic          busy, rect_done, clear_done, rect_abort;

  fb_write_sched #(
    .W_RES (W),
    .H_RES (H),
    .CW    (CW)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .clear_req  (clear_req),
    .clear_rgb  (clear_rgb),
    .rect_valid (rect_valid),
    .rect_ready (rect_ready),
    .rect_x     (rect_x),
    .rect_y     (rect_y),
    .rect_w     (rect_w),
    .rect_h     (rect_h),
    .rect_rgb   (rect_rgb),
    .wr_en      (wr_en),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_rgb     (wr_rgb),
    .busy       (busy),
    .rect_done  (rect_done),
    .clear_done (clear_done),
    .rect_abort (rect_abort)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    int          x, y, w, h;
    logic [23:0] rgb;
    int          ex0, ey0, ex1, ey1, en;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Presents a command in an IDLE cycle and lets the next edge accept it.
  task automatic issue_rect(input int x, input int y, input int w, input int h,
                            input logic [23:0] rgb, input string name);
    for (int i = 0; i < 20 && busy; i++) tick();
    rect_x     = CW'(x);
    rect_y     = CW'(y);
    rect_w     = CW'(w);
    rect_h     = CW'(h);
    rect_rgb   = rgb;
    rect_valid = 1'b1;
    #1;
    chk({name, ".ready"}, 32'(rect_ready), 32'd1);
    @(posedge clock);
    #1;
    rect_valid = 1'b0;
  endtask

  // Called on the first sample after the accepting edge.
  task automatic watch_rect(input int ex0, input int ey0, input int ex1, input int ey1,
                            input logic [23:0] rgb, input int en, input string name);
    int cx, cy, nwr, first, done_at, pos_err;
    cx = ex0; cy = ey0; nwr = 0; first = -1; done_at = -1; pos_err = 0;
    for (int c = 0; c < en + 8; c++) begin
      if (wr_en) begin
        if (first < 0) first = c;
        if (wr_x !== CW'(cx) || wr_y !== CW'(cy) || wr_rgb !== rgb) pos_err++;
        nwr++;
        if (cx == ex1) begin
          cx = ex0;
          cy++;
        end else begin
          cx++;
        end
      end
      if (rect_done) begin
        done_at = c;
        break;
      end
      tick();
    end
    chk({name, ".writes"}, 32'(nwr), 32'(en));
    chk({name, ".raster"}, 32'(pos_err), 32'd0);
    chk({name, ".done_at"}, 32'(done_at), (en == 0) ? 32'd0 : 32'(en - 1));
    chk({name, ".first"}, 32'(first), (en == 0) ? 32'hFFFF_FFFF : 32'd0);
    tick();
    chk({name, ".idle_after"}, 32'({wr_en, rect_done}), 32'd0);
  endtask

  // Called on the first sample after the edge that captured clear_req.
  task automatic watch_clear(input logic [23:0] rgb, input string name);
    int cx, cy, nwr, first, done_at, pos_err, gap, leak, busy_err;
    cx = 0; cy = 0; nwr = 0; first = -1; done_at = -1; pos_err = 0; gap = 0;
    leak = 0; busy_err = 0;
    for (int c = 0; c < int'(W * H) + 20; c++) begin
      if (rect_ready) leak++;
      if (wr_en) begin
        if (first < 0) first = c;
        if (wr_x !== CW'(cx) || wr_y !== CW'(cy) || wr_rgb !== rgb) pos_err++;
        if (busy !== 1'b1) busy_err++;
        nwr++;
        if (cx == int'(W) - 1) begin
          cx = 0;
          cy++;
        end else begin
          cx++;
        end
      end else if (first >= 0) begin
        gap++;
      end
      if (clear_done) begin
        done_at = nwr;
        break;
      end
      tick();
    end
    chk({name, ".writes"}, 32'(nwr), 32'(W * H));
    chk({name, ".done_on_last"}, 32'(done_at), 32'(W * H));
    chk({name, ".raster"}, 32'(pos_err), 32'd0);
    chk({name, ".gaps"}, 32'(gap), 32'd0);
    chk({name, ".busy"}, 32'(busy_err), 32'd0);
    chk({name, ".ready_low"}, 32'(leak), 32'd0);
    chk({name, ".start"}, 32'(first >= 0 && first <= 3), 32'd1);
    tick();
    chk({name, ".idle_after"}, 32'({wr_en, clear_done, busy}), 32'd0);
  endtask

  initial begin
    int n_rect, n_clr, stray;
    bit done_seen, abort_seen, abort_ok, sent;

    vecs[0] = '{100, 50, 8, 8, 24'hF80000, 100, 50, 107, 57, 64};
    vecs[1] = '{124, 94, 8, 8, 24'h07E0F0, 124, 94, 127, 95, 8};
    vecs[2] = '{10, 10, 0, 5, 24'h111111, 0, 0, 0, 0, 0};
    vecs[3] = '{200, 5, 4, 4, 24'h222222, 0, 0, 0, 0, 0};
    vecs[4] = '{0, 0, 1, 1, 24'h333333, 0, 0, 0, 0, 1};
    vecs[5] = '{5, 95, 3, 4, 24'h444444, 5, 95, 7, 95, 3};
    vecs[6] = '{3, 100, 2, 2, 24'h555555, 0, 0, 0, 0, 0};
    vecs[7] = '{120, 3, 20, 1, 24'h666666, 120, 3, 127, 3, 8};
    vecs[8] = '{7, 9, 4, 0, 24'h777777, 0, 0, 0, 0, 0};

    reset = 1'b1; clear_req = 1'b0; clear_rgb = '0; rect_valid = 1'b0;
    rect_x = '0; rect_y = '0; rect_w = '0; rect_h = '0; rect_rgb = '0;
    repeat (3) tick();
    chk("rst.wr_en", 32'(wr_en), 32'd0);
    chk("rst.wr_xy", 32'({wr_x, wr_y}), 32'd0);
    chk("rst.wr_rgb", 32'(wr_rgb), 32'd0);
    chk("rst.flags", 32'({busy, rect_done, clear_done, rect_abort}), 32'd0);
    chk("rst.ready", 32'(rect_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("idle.ready", 32'(rect_ready), 32'd1);

    // Full clear to black.
    clear_rgb = 24'h000000;
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    watch_clear(24'h000000, "clear0");

    foreach (vecs[i]) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      issue_rect(vecs[i].x, vecs[i].y, vecs[i].w, vecs[i].h, vecs[i].rgb, nm);
      watch_rect(vecs[i].ex0, vecs[i].ey0, vecs[i].ex1, vecs[i].ey1, vecs[i].rgb, vecs[i].en,
                 nm);
    end

    // Clear and rect in the same IDLE cycle: clear first, rect held until after clear_done.
    clear_rgb  = 24'h0000FF;
    clear_req  = 1'b1;
    rect_x     = CW'(100);
    rect_y     = CW'(50);
    rect_w     = CW'(2);
    rect_h     = CW'(2);
    rect_rgb   = 24'hABCDEF;
    rect_valid = 1'b1;
    #1;
    chk("simul.ready_low", 32'(rect_ready), 32'd0);
    tick();
    clear_req = 1'b0;
    watch_clear(24'h0000FF, "simul.clear");
    chk("simul.ready_after", 32'(rect_ready), 32'd1);
    @(posedge clock);
    #1;
    rect_valid = 1'b0;
    watch_rect(100, 50, 101, 51, 24'hABCDEF, 4, "simul.rect");

    // Clear request at the 10th write of a 64-pixel fill.
    clear_rgb = 24'hFF00FF;
    issue_rect(10, 10, 8, 8, 24'h00FF00, "pre");
    n_rect = 0; n_clr = 0; done_seen = 0; abort_seen = 0; abort_ok = 0; sent = 0;
    for (int c = 0; c < 200; c++) begin
      clear_req = 1'b0;
      if (wr_en && wr_rgb == 24'h00FF00) begin
        n_rect++;
        if (n_rect == 10 && !sent) begin
          clear_req = 1'b1;
          sent = 1;
        end
      end
      if (wr_en && wr_rgb == 24'hFF00FF) n_clr++;
      if (rect_done) done_seen = 1;
      if (rect_abort) begin
        abort_seen = 1;
        abort_ok = wr_en && wr_x == '0 && wr_y == '0 && wr_rgb == 24'hFF00FF;
      end
      if (n_clr >= 20) break;
      tick();
    end
    clear_req = 1'b0;
`ifdef CLEAR_PREEMPT_EN
    chk("pre.rect_writes", 32'(n_rect), 32'd10);
    chk("pre.done", 32'(done_seen), 32'd0);
    chk("pre.abort", 32'(abort_seen), 32'd1);
    chk("pre.abort_clear_start", 32'(abort_ok), 32'd1);
`else
    chk("pre.rect_writes", 32'(n_rect), 32'd64);
    chk("pre.done", 32'(done_seen), 32'd1);
    chk("pre.abort", 32'(abort_seen), 32'd0);
`endif
    chk("pre.clear_started", 32'(n_clr), 32'd20);

    // Reset in the middle of that clear.
    reset = 1'b1;
    tick();
    chk("midrst.wr_en", 32'(wr_en), 32'd0);
    chk("midrst.flags", 32'({busy, clear_done, rect_done, rect_abort}), 32'd0);
    chk("midrst.wr", 32'({wr_x, wr_y, wr_rgb}), 32'd0);
    reset = 1'b0;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (wr_en || clear_done || busy) stray++;
    end
    chk("midrst.quiet", 32'(stray), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
